wrr_arbiter: RTL and testbench
==============================

WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; SHALL be >= 2.
REQ-002 Parameter WEIGHT_W, default 4: width of each per-channel weight field.
REQ-003 Port clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port req  input  N: per-channel request level; bit i = channel i.
REQ-006 Port weight  input  N*WEIGHT_W: channel i weight at bits [i*WEIGHT_W +: WEIGHT_W]; 0 = channel disabled.
REQ-007 Port done  input  1: pulse from the current grant holder; each pulse ends one transaction.
REQ-008 Port grant  output  N: registered one-hot grant, or all-zero.
REQ-009 Port grant_idx  output  $clog2(N): registered binary index of the holder; valid only while grant_valid=1.
REQ-010 Port grant_valid  output  1: registered; equals |grant.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant) and HOLD (one channel granted).
REQ-012 Eligible set SHALL be req[i] & (weight[i] != 0).
- IDLE with any channel eligible in cycle t: grant one-hot, grant_idx and grant_valid SHALL assert in cycle t+1; state -> HOLD.
REQ-013 Selection SHALL be round-robin: lowest-index eligible channel at or above pointer ptr.
- If none: lowest-index eligible channel overall (wrap-around).
REQ-014 On entering HOLD, a credit counter (WEIGHT_W bits) SHALL load weight[grant_idx], sampled in the arbitration cycle.
- Weight changes during HOLD SHALL have no effect until the next arbitration.
REQ-015 In HOLD, each cycle with done=1 and credit>1 and req[grant_idx]=1 SHALL decrement credit; grant is held.
REQ-016 In HOLD, release SHALL occur in cycle t when any of the following holds; grant drops to 0 and state -> IDLE in t+1:
- done=1 and credit=1;
- req[grant_idx]=0, including same-cycle done.
REQ-017 On release, ptr SHALL become (grant_idx+1) mod N, wrapping N-1 -> 0.
REQ-018 After release, grant SHALL stay all-zero for exactly one cycle (the arbitration cycle).
- Next grant earliest t+2 after a release in cycle t.
REQ-019 done in IDLE SHALL be ignored.
REQ-020 grant SHALL never have more than one bit set.
REQ-021 A channel with weight 0 SHALL never be granted.
- Weight set to 0 while that channel holds the grant SHALL NOT release it; release follows REQ-016 only.

Reset
REQ-022 rst=1 at a clock edge SHALL force in the next cycle:
- state=IDLE; grant=0, grant_idx=0, grant_valid=0;
- credit=0; ptr=0.
REQ-023 Reset SHALL take precedence over every other event, including mid-HOLD with done asserted.
REQ-024 The first arbitration after reset SHALL favour channel 0.

Structure
REQ-025 A shared package wrr_arbiter_pkg SHALL hold the FSM state type (IDLE, HOLD) and the index-width function.
REQ-026 Round-robin selection SHALL be a combinational sub-module rr_prio_pick.
- Inputs: eligible vector, ptr.
- Outputs: one-hot pick, binary index, any.
- Implementation: masked and unmasked priority encoders.
REQ-027 The top level SHALL contain only the FSM, credit counter, ptr register and output registers.

Verification
REQ-028 Reset then req=4'b1111, all weights 1, done pulsed every grant -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-029 req=4'b0011, weight0=3, weight1=1, done every cycle while granted -> ch0 held for 3 done pulses, 1-cycle gap, ch1 for 1, gap, ch0 again.
REQ-030 req=4'b1001 with ptr=3 after reset-sequence -> ch3 granted; on release ptr wraps to 0 and ch0 is granted next.
REQ-031 weight2=0, req=4'b0100 -> grant stays 0 indefinitely; then set weight2=2 -> grant=0100 two cycles later.
REQ-032 ch1 granted with credit 5, req[1] dropped with no done -> grant=0 next cycle, ptr=2.
REQ-033 rst asserted mid-HOLD with done=1 -> next cycle grant=0; with req=4'b0110 the first post-reset grant is 0010.

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Index width with a floor of one bit so degenerate sizes still elaborate.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_prio_pick.sv
// Combinational round-robin pick: lowest eligible index at or above ptr,
// falling back to the lowest eligible index overall.
module rr_prio_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          any
);

    logic [N-1:0]  mask;
    logic [N-1:0]  masked;
    logic [IW-1:0] idx_masked;
    logic [IW-1:0] idx_all;
    logic          any_masked;

    always_comb begin
        mask       = '0;
        idx_masked = '0;
        idx_all    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (IW'(i) >= ptr);
        end
        masked = eligible & mask;
        // Descending scan so the last hit is the lowest set index.
        for (int unsigned i = N; i > 0; i--) begin
            if (masked[i-1])   idx_masked = IW'(i - 1);
            if (eligible[i-1]) idx_all    = IW'(i - 1);
        end
        any_masked = |masked;
        any        = |eligible;
        pick_idx   = any_masked ? idx_masked : idx_all;
        pick       = '0;
        if (any) pick[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a granted channel keeps the grant for up to
// weight done pulses, then the pointer advances past it.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned WEIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*WEIGHT_W-1:0] weight,
    input  logic                  done,
    output logic [N-1:0]          grant,
    output logic [$clog2(N)-1:0]  grant_idx,
    output logic                  grant_valid
);

    localparam int unsigned IW = idx_w(N);

    state_t              state, state_nxt;
    logic [WEIGHT_W-1:0] credit, credit_nxt;
    logic [IW-1:0]       ptr, ptr_nxt;
    logic [N-1:0]        grant_nxt;
    logic [IW-1:0]       idx_nxt;
    logic [WEIGHT_W-1:0] w_arr [N];
    logic [N-1:0]        eligible;
    logic [N-1:0]        pick;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                release_now;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            w_arr[i]    = weight[i*WEIGHT_W +: WEIGHT_W];
            eligible[i] = req[i] & (w_arr[i] != '0);
        end
    end

    rr_prio_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // Release ignores the live weight: only request drop or exhausted credit.
    assign release_now = !req[grant_idx] || (done && credit == WEIGHT_W'(1));

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        idx_nxt    = grant_idx;
        credit_nxt = credit;
        ptr_nxt    = ptr;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt  = HOLD;
                    grant_nxt  = pick;
                    idx_nxt    = pick_idx;
                    credit_nxt = w_arr[pick_idx];
                end
            end
            HOLD: begin
                if (release_now) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
                end else if (done) begin
                    credit_nxt = credit - WEIGHT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            credit      <= '0;
            ptr         <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= |grant_nxt;
            credit      <= credit_nxt;
            ptr         <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios with literal grant sequences,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wrr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*WW-1:0] weight;
    logic          done;
    logic [N-1:0]  grant;
    logic [1:0]    grant_idx;
    logic          grant_valid;

    int vectors = 0;
    int miscompares = 0;

    // Model state: who holds the grant (-1 = nobody), remaining credit, pointer.
    int m_holder = -1;
    int m_credit = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    wrr_arbiter #(
        .N        (N),
        .WEIGHT_W (WW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .weight      (weight),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    function automatic int wt(input int c);
        logic [WW-1:0] f;
        f = weight[c*WW +: WW];
        return int'(f);
    endfunction

    always @(posedge clk) begin
        int c;
        int found;
        if (rst) begin
            m_holder = -1;
            m_ptr    = 0;
            m_credit = 0;
        end else if (m_holder < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (found == 0 && req[c] && wt(c) != 0) begin
                    m_holder = c;
                    m_credit = wt(c);
                    found    = 1;
                end
            end
        end else if (!req[m_holder] || (done && m_credit == 1)) begin
            m_ptr    = (m_holder + 1) % N;
            m_holder = -1;
        end else if (done) begin
            m_credit = m_credit - 1;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_g;
        exp_g = (m_holder < 0) ? '0 : (N'(1) << m_holder);
        vectors++;
        if (grant !== exp_g) begin
            miscompares++;
            $display("FAIL model_grant t=%0t got=%b exp=%b", $time, grant, exp_g);
        end
        vectors++;
        if (grant_valid !== (m_holder >= 0)) begin
            miscompares++;
            $display("FAIL model_valid t=%0t got=%b exp=%b", $time, grant_valid, (m_holder >= 0));
        end
        vectors++;
        if (!$onehot0(grant)) begin
            miscompares++;
            $display("FAIL onehot t=%0t got=%b exp=at_most_one_bit", $time, grant);
        end
        if (m_holder >= 0) begin
            vectors++;
            if (grant_idx !== 2'(m_holder)) begin
                miscompares++;
                $display("FAIL model_idx t=%0t got=%0d exp=%0d", $time, grant_idx, m_holder);
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] exp_g);
        vectors++;
        if (grant !== exp_g || grant_valid !== (|exp_g)) begin
            miscompares++;
            $display("FAIL %s t=%0t got grant=%b valid=%b exp grant=%b valid=%b",
                     name, $time, grant, grant_valid, exp_g, |exp_g);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        done = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    logic [N-1:0] seq_rr  [9];
    logic [N-1:0] seq_wt  [7];

    initial begin
        seq_rr = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};
        seq_wt = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};

        rst = 1'b1; req = '0; weight = '0; done = 1'b0;
        @(negedge clk);
        chk("reset_grant", 4'b0000);
        vectors++;
        if (grant_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_idx got=%0d exp=0", grant_idx);
        end
        rst = 1'b0;

        // Equal weights of 1: plain rotation with one idle cycle between grants.
        do_reset();
        req = 4'b1111; weight = 16'h1111; done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rr_seq", seq_rr[k]);
        end

        // ch0 weight 3 keeps the grant for three done pulses.
        do_reset();
        req = 4'b0011; weight = 16'h0013; done = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("weight_seq", seq_wt[k]);
        end

        // Zero weight blocks the channel until the weight becomes nonzero.
        do_reset();
        req = 4'b0100; weight = 16'h0000; done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("zero_weight", 4'b0000);
        end
        weight = 16'h0200;
        @(negedge clk);
        @(negedge clk);
        chk("weight_enable", 4'b0100);

        // Pointer at 3 after serving ch2: ch3 first, then wrap to ch0.
        do_reset();
        req = 4'b0100; weight = 16'h1111; done = 1'b1;
        @(negedge clk); chk("ptr_setup", 4'b0100);
        req = 4'b1001;
        @(negedge clk); chk("ptr_gap", 4'b0000);
        @(negedge clk); chk("ptr_ch3", 4'b1000);
        @(negedge clk); chk("ptr_gap2", 4'b0000);
        @(negedge clk); chk("ptr_wrap", 4'b0001);

        // Request drop releases immediately regardless of remaining credit.
        do_reset();
        req = 4'b0010; weight = 16'h0050; done = 1'b0;
        @(negedge clk); chk("drop_grant", 4'b0010);
        @(negedge clk); chk("drop_hold", 4'b0010);
        req = 4'b0000;
        @(negedge clk); chk("drop_release", 4'b0000);
        req = 4'b0111; weight = 16'h0111;
        @(negedge clk); chk("drop_ptr2", 4'b0100);

        // Reset mid-hold with done high; pointer returns to 0.
        do_reset();
        req = 4'b0110; weight = 16'h0310; done = 1'b1;
        @(negedge clk); chk("mid_ch1", 4'b0010);
        @(negedge clk); chk("mid_gap", 4'b0000);
        @(negedge clk); chk("mid_ch2", 4'b0100);
        rst = 1'b1;
        @(negedge clk); chk("mid_reset", 4'b0000);
        rst = 1'b0; done = 1'b0;
        @(negedge clk); chk("post_reset", 4'b0010);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 9) < 3) req = N'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < N; i++) begin
                    weight[i*WW +: WW] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
                end
            end
            done = 1'($urandom_range(0, 1));
            rst  = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
